tile_scan_ctrl: RTL



---
 rtl/scan_pkg.sv | 23 ++
 rtl/tile_coord_counter.sv | 50 +++++
 rtl/tile_scan_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared types and geometry for the tile scan sequencer.
// A 4x4 tile holds 2x2 overlapping 3x3 windows.
package scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WIN   = 3'd2,
    S_ADV   = 3'd3,
    S_DONE  = 3'd4
  } scan_state_t;

  localparam int TILE_DIM = 4;
  localparam int STRIDE   = 2;
  localparam int WIN_DIM  = 3;

  // Window positions per tile, walked in raster order.
  localparam int WIN_PER_AXIS  = TILE_DIM - WIN_DIM + 1;
  localparam int WIN_POSITIONS = WIN_PER_AXIS * WIN_PER_AXIS;

  typedef logic [3:0] pixel_t;

endpackage

// File: rtl/tile_coord_counter.sv
// Tile top-left coordinate walker: raster order at stride 2 over the frame.
// Wraps to the origin after the last tile so a finished frame leaves it at (0,0).
module tile_coord_counter
  import scan_pkg::*;
#(
  parameter int IMG_WIDTH  = 400,
  parameter int IMG_HEIGHT = 300,
  parameter int CW         = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] tile_x,
  output logic [CW-1:0] tile_y,
  output logic          last_tile
);

  localparam logic [CW-1:0] X_LAST = CW'(IMG_WIDTH - TILE_DIM);
  localparam logic [CW-1:0] Y_LAST = CW'(IMG_HEIGHT - TILE_DIM);
  localparam logic [CW-1:0] STEP   = CW'(STRIDE);

  logic row_end;

  assign row_end   = (tile_x == X_LAST);
  assign last_tile = row_end && (tile_y == Y_LAST);

  // Coordinate registers; clear has priority over advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_x <= '0;
      tile_y <= '0;
    end else if (clear) begin
      tile_x <= '0;
      tile_y <= '0;
    end else if (advance) begin
      if (row_end) begin
        tile_x <= '0;
        tile_y <= last_tile ? '0 : tile_y + STEP;
      end else begin
        tile_x <= tile_x + STEP;
        tile_y <= tile_y;
      end
    end else begin
      tile_x <= tile_x;
      tile_y <= tile_y;
    end
  end

endmodule

// File: rtl/tile_scan_ctrl.sv
// Frame scan sequencer for image_buffer: fetches 4x4 tiles at stride 2 and
// steps the buffer through its four 3x3 window positions under filter handshake.
module tile_scan_ctrl
  import scan_pkg::*;
#(
  parameter int IMG_WIDTH  = 400,
  parameter int IMG_HEIGHT = 300,
  parameter int CW         = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          fetch_req,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y,
  input  logic          fetch_ack,
  output logic          load_enable,
  output logic          calc_done,
  output logic          win_valid,
  output logic [CW-1:0] win_x,
  output logic [CW-1:0] win_y,
  input  logic          filt_ack,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] POS_LAST = 2'(WIN_POSITIONS - 1);

  scan_state_t   state;
  logic [1:0]    pos;
  logic [CW-1:0] tile_x;
  logic [CW-1:0] tile_y;
  logic          last_tile;
  logic          coord_clear;
  logic          coord_advance;

  assign coord_clear   = abort || (state == S_DONE);
  assign coord_advance = (state == S_ADV) && !abort;

  tile_coord_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .CW         (CW)
  ) u_coord (
    .clk       (clk),
    .rst       (rst),
    .clear     (coord_clear),
    .advance   (coord_advance),
    .tile_x    (tile_x),
    .tile_y    (tile_y),
    .last_tile (last_tile)
  );

  // Strobes to image_buffer are same-cycle with the handshake; abort suppresses them.
  assign load_enable = (state == S_FETCH) && fetch_ack && !abort;
  assign calc_done   = (state == S_WIN) && filt_ack && !abort;

  assign fetch_x = tile_x;
  assign fetch_y = tile_y;
  assign win_x   = tile_x + {{(CW-1){1'b0}}, pos[0]};
  assign win_y   = tile_y + {{(CW-1){1'b0}}, pos[1]};

  // Scan FSM with registered status outputs and window position counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pos       <= 2'd0;
      fetch_req <= 1'b0;
      win_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state     <= S_IDLE;
      pos       <= 2'd0;
      fetch_req <= 1'b0;
      win_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            fetch_req <= 1'b1;
            busy      <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_FETCH: begin
          if (fetch_ack) begin
            state     <= S_WIN;
            pos       <= 2'd0;
            fetch_req <= 1'b0;
            win_valid <= 1'b1;
          end else begin
            state <= S_FETCH;
          end
        end
        S_WIN: begin
          if (filt_ack) begin
            if (pos == POS_LAST) begin
              state     <= S_ADV;
              pos       <= 2'd0;
              win_valid <= 1'b0;
            end else begin
              pos <= pos + 2'd1;
            end
          end else begin
            state <= S_WIN;
          end
        end
        S_ADV: begin
          if (last_tile) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state     <= S_FETCH;
            fetch_req <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          pos       <= 2'd0;
          fetch_req <= 1'b0;
          win_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
